// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the pipelined RV32 data memory.
// Size encodings, response stage record, byte-count and lane-mask helpers.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    unique case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

  // Byte lanes touched by an access; assumes the access is already aligned.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] m;
    unique case (size)
      SIZE_BYTE: m = 4'b0001 << offset;
      SIZE_HALF: m = 4'b0011 << offset;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_load_align.sv
// Load extraction: picks the addressed byte/half out of a word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    data   = '0;
    unique case (size)
      SIZE_BYTE: data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      SIZE_HALF: data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      SIZE_WORD: data = word;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_pipelined.sv
// Byte-addressed RV32 data memory with valid/ready requests and a fixed-latency response pipe.
// Misaligned, out-of-range and illegal-size requests are flagged rather than wrapped.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 1048576,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "",
  parameter int unsigned INIT_WORDS   = 0
) (
  input  logic   clock,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int unsigned Words = MEM_BYTES / 4;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;

  logic [31:0] mem_q [Words];

  logic [ADDR_W-1:0] addr;
  logic [1:0]        offset;
  logic [IdxW-1:0]   idx;
  logic [63:0]       end_addr;
  logic              accept;
  logic              misaligned;
  logic              req_err;
  logic [31:0]       rd_word;
  logic [31:0]       load_data;
  logic [31:0]       wdata_lane;
  logic [3:0]        wmask;

  assign bus.req_ready = ~reset;
  assign accept        = bus.req_valid & bus.req_ready;

  assign addr   = bus.req_addr;
  assign offset = addr[1:0];
  assign idx    = addr[IdxW+1:2];

  // Range check in 64 bits so high address bits can never alias back into the array.
  assign end_addr   = 64'(addr) + 64'(size_bytes(bus.req_size));
  assign misaligned = ((bus.req_size == SIZE_HALF) && offset[0]) ||
                      ((bus.req_size == SIZE_WORD) && (offset != 2'b00));
  assign req_err    = (bus.req_size == SIZE_ILLEGAL) || misaligned ||
                      (end_addr > 64'(MEM_BYTES));

  assign rd_word    = req_err ? '0 : mem_q[idx];
  assign wdata_lane = bus.req_wdata << {offset, 3'b000};
  assign wmask      = byte_mask(bus.req_size, offset);

  dmem_load_align u_load_align (
    .word        (rd_word),
    .offset      (offset),
    .size        (bus.req_size),
    .is_unsigned (bus.req_unsigned),
    .data        (load_data)
  );

  // Storage has no reset: committed writes survive a reset pulse.
  always_ff @(posedge clock) begin
    if (accept && bus.req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

  resp_t stage0_d;
  resp_t pipe_q [READ_LATENCY];

  always_comb begin
    stage0_d = '0;
    if (accept) begin
      stage0_d.valid = 1'b1;
      stage0_d.err   = req_err;
      stage0_d.rdata = (req_err || bus.req_write) ? '0 : load_data;
    end
  end

  // Idle stages carry all-zero records, so rdata/err read as 0 whenever valid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage0_d;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.resp_valid = pipe_q[READ_LATENCY-1].valid;
  assign bus.resp_err   = pipe_q[READ_LATENCY-1].err;
  assign bus.resp_rdata = pipe_q[READ_LATENCY-1].rdata;

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed bench for dmem_pipelined: stores, extended loads, error cases, streaming and reset.
module tb_dmem_pipelined;

  localparam int unsigned MemBytes = 65536;
  localparam int          L        = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dmem_if #(.ADDR_W(32)) bus ();

  dmem_pipelined #(
    .MEM_BYTES    (MemBytes),
    .ADDR_W       (32),
    .READ_LATENCY (L),
    .INIT_FILE    (""),
    .INIT_WORDS   (0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  // One isolated request; checks the exact response cycle and its payload.
  task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clock);
    drive(wr, addr, size, uns, wdata);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i < L; i++) begin
      check_eq({tag, "/early"}, 32'(bus.resp_valid), 32'd0);
      @(posedge clock);
      #1;
    end
    check_eq({tag, "/valid"}, 32'(bus.resp_valid), 32'd1);
    check_eq({tag, "/rdata"}, bus.resp_rdata, exp_rdata);
    check_eq({tag, "/err"}, 32'(bus.resp_err), 32'(exp_err));
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;

    // Reset state
    #12;
    check_eq("rst/ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst/valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst/rdata", bus.resp_rdata, 32'd0);
    check_eq("rst/err", 32'(bus.resp_err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check_eq("rst/ready_after", 32'(bus.req_ready), 32'd1);

    // 1: word store then load
    xact("t1_sw", 1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("t1_lw", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    @(posedge clock);
    #1 check_eq("t1/pulse_end", 32'(bus.resp_valid), 32'd0);

    // 2: byte/half stores only touch their lanes; signed and unsigned extension
    xact("t2_sw", 1'b1, 32'h200, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0);
    xact("t2_sb", 1'b1, 32'h203, 2'd0, 1'b0, 32'hAAAAAA80, 32'h0, 1'b0);
    xact("t2_lw", 1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 32'h80223344, 1'b0);
    xact("t2_lb", 1'b0, 32'h203, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("t2_lbu", 1'b0, 32'h203, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b0);
    xact("t2_lb2", 1'b0, 32'h202, 2'd0, 1'b0, 32'h0, 32'h00000022, 1'b0);
    xact("t2_sh", 1'b1, 32'h206, 2'd1, 1'b0, 32'h55558001, 32'h0, 1'b0);
    xact("t2_lh", 1'b0, 32'h206, 2'd1, 1'b0, 32'h0, 32'hFFFF8001, 1'b0);
    xact("t2_lhu", 1'b0, 32'h206, 2'd1, 1'b1, 32'h0, 32'h00008001, 1'b0);

    // 3: misaligned accesses
    xact("t3_sw4", 1'b1, 32'h104, 2'd2, 1'b0, 32'h01234567, 32'h0, 1'b0);
    xact("t3_lh_mis", 1'b0, 32'h101, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("t3_sw_mis", 1'b1, 32'h102, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("t3_lw100", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("t3_lw104", 1'b0, 32'h104, 2'd2, 1'b0, 32'h0, 32'h01234567, 1'b0);

    // 4: range edges, illegal size, no aliasing
    xact("t4_sw_top", 1'b1, MemBytes - 4, 2'd2, 1'b0, 32'h55AA55AA, 32'h0, 1'b0);
    xact("t4_lw_top", 1'b0, MemBytes - 4, 2'd2, 1'b0, 32'h0, 32'h55AA55AA, 1'b0);
    xact("t4_lw_end", 1'b0, MemBytes, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("t4_lbu_top", 1'b0, MemBytes - 1, 2'd0, 1'b1, 32'h0, 32'h00000055, 1'b0);
    xact("t4_lh_top", 1'b0, MemBytes - 2, 2'd1, 1'b0, 32'h0, 32'h000055AA, 1'b0);
    xact("t4_size3", 1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("t4_sw_alias", 1'b1, MemBytes + 32'h100, 2'd2, 1'b0, 32'h0BADF00D, 32'h0, 1'b1);
    xact("t4_lw_hi", 1'b0, 32'h80000100, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("t4_lw100", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    // 5: eight back-to-back loads stream out in order, L cycles after the first request
    for (int i = 0; i < 8; i++) begin
      xact("t5_fill", 1'b1, 32'h400 + 32'(4 * i), 2'd2, 1'b0, 32'h11110000 + 32'(i),
           32'h0, 1'b0);
    end
    for (int k = 0; k < 8 + L; k++) begin
      int j;
      @(negedge clock);
      if (k < 8) drive(1'b0, 32'h400 + 32'(4 * k), 2'd2, 1'b0, 32'h0);
      else bus.req_valid = 1'b0;
      @(posedge clock);
      #1;
      j = k - (L - 1);
      if (j >= 0 && j < 8) begin
        check_eq("t5/valid", 32'(bus.resp_valid), 32'd1);
        check_eq("t5/rdata", bus.resp_rdata, 32'h11110000 + 32'(j));
      end else begin
        check_eq("t5/idle", 32'(bus.resp_valid), 32'd0);
      end
    end
    bus.req_valid = 1'b0;

    // 6: reset with two loads in flight drops them; memory keeps its contents
    xact("t6_sw", 1'b1, 32'h500, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clock);
    drive(1'b0, 32'h400, 2'd2, 1'b0, 32'h0);
    @(posedge clock);
    #1 drive(1'b0, 32'h404, 2'd2, 1'b0, 32'h0);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("t6/ready_in_rst", 32'(bus.req_ready), 32'd0);
    check_eq("t6/valid_in_rst", 32'(bus.resp_valid), 32'd0);
    repeat (2) begin
      @(posedge clock);
      #1 check_eq("t6/valid_rst_hold", 32'(bus.resp_valid), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1 check_eq("t6/no_ghost", 32'(bus.resp_valid), 32'd0);
    end
    xact("t6_lw500", 1'b0, 32'h500, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    xact("t6_lw400", 1'b0, 32'h400, 2'd2, 1'b0, 32'h0, 32'h11110000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
